// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared defaults and state type for the RAM request controller
package ram_ctrl_pkg;
  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_DEF   = 10;
  localparam int DEPTH_DEF  = 1024;
  localparam int RD_LAT_DEF = 1;
  typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo: small response FIFO with occupancy count, push and pop allowed together
module ram_rsp_fifo #(
  parameter  int W  = 32,
  parameter  int D  = 2,
  localparam int PW = $clog2(D),
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr_en, rd_en;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign full_o  = cnt_q == CW'(D);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  // storage and pointers; storage is cleared so the head reads zero in reset
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= nxt(wr_q);
      end
      if (rd_en) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: single-port RAM front end with credit-limited read responses; RAM_CLEAR_EN adds a zeroing sweep after reset
module ram_req_ctrl import ram_ctrl_pkg::*; #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR   = ADDR_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             ram_ena,
  output logic             ram_wea,
  output logic [ADDR-1:0]  ram_addra,
  output logic [WIDTH-1:0] ram_dina,
  input  logic [WIDTH-1:0] ram_douta,
  output logic             busy
);
  localparam int FD = RD_LAT + 1;
  localparam int CW = $clog2(FD + 1);
`ifdef RAM_CLEAR_EN
  localparam state_t RST_ST = CLEAR;
`else
  localparam state_t RST_ST = RUN;
`endif
  state_t           state_q;
  logic [ADDR-1:0]  sweep_q, addr_q;
  logic [WIDTH-1:0] din_q;
  logic             ena_q, we_q;
  logic [RD_LAT:0]  pipe_q;
  logic [CW-1:0]    fifo_cnt;
  logic [CW:0]      pend;
  logic             fifo_full, fifo_empty, credit, acc, rd_acc;
  // outstanding reads: still in the RAM pipeline plus already parked in the FIFO
  always_comb begin
    pend = (CW + 1)'(fifo_cnt);
    for (int i = 0; i <= RD_LAT; i++) pend = pend + (CW + 1)'(pipe_q[i]);
  end
  // a read needs a guaranteed FIFO slot even if the consumer stalls from now on
  assign credit    = (pend < (CW + 1)'(FD)) && !fifo_full;
  assign cmd_ready = rsta && (state_q == RUN) && (cmd_we || credit);
  assign acc       = cmd_valid && cmd_ready;
  assign rd_acc    = acc && !cmd_we;
`ifdef RAM_CLEAR_EN
  assign busy = rsta && (state_q == CLEAR);
`else
  assign busy = 1'b0;
`endif
  assign ram_ena   = ena_q;
  assign ram_wea   = we_q;
  assign ram_addra = addr_q;
  assign ram_dina  = din_q;
  assign rsp_valid = !fifo_empty;
  // state, registered RAM port and read-latency tracker
  always_ff @(posedge clka or negedge rsta)
    if (!rsta) begin
      state_q <= RST_ST;
      sweep_q <= '0;
      ena_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      pipe_q  <= '0;
    end else begin
      pipe_q <= {pipe_q[RD_LAT-1:0], rd_acc};
      if (state_q == CLEAR) begin
        ena_q   <= 1'b1;
        we_q    <= 1'b1;
        addr_q  <= sweep_q;
        din_q   <= '0;
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == ADDR'(DEPTH - 1)) state_q <= RUN;
      end else begin
        ena_q <= acc;
        we_q  <= acc && cmd_we;
        if (acc) begin
          addr_q <= cmd_addr;
          din_q  <= cmd_wdata;
        end
      end
    end
  ram_rsp_fifo #(.W(WIDTH), .D(FD)) u_fifo (
    .clk_i   (clka),
    .rst_ni  (rsta),
    .push_i  (pipe_q[RD_LAT]),
    .din_i   (ram_douta),
    .pop_i   (rsp_ready),
    .dout_o  (rsp_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );
endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: scoreboard bench for ram_req_ctrl with a behavioural single-port RAM; RAM_CLEAR_EN selects the sweep variant
module tb_ram_req_ctrl;
  localparam int WIDTH = 32, ADDR = 10, DEPTH = 1024, RD_LAT = 1;
  logic clka = 1'b0;
  logic rsta, cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, ram_ena, ram_wea, busy;
  logic [ADDR-1:0]  cmd_addr, ram_addra;
  logic [WIDTH-1:0] cmd_wdata, rsp_rdata, ram_dina, ram_douta;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_pipe [RD_LAT];
  bit               init_done;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int n_err, n_chk, rsp_n, wr_stall, acc, base;

  always #10 clka = ~clka;

  ram_req_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clka(clka), .rsta(rsta), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta), .busy(busy)
  );

  function automatic logic [WIDTH-1:0] init_val(input int i);
`ifdef RAM_CLEAR_EN
    return '1 | WIDTH'(i);
`else
    return 32'hC0DE_0000 | WIDTH'(i);
`endif
  endfunction

  // behavioural RAM: preloaded image, RD_LAT-cycle registered read
  always @(posedge clka) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      rd_pipe[0] <= mem[ram_addra];
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_douta = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, rsp_valid, ram_ena, ram_wea, busy, ram_addra}, 0);
    chk({tag, "_dat"}, {rsp_rdata, ram_dina}, 0);
  endtask

  // response monitor: every handshake must match the oldest expected read
  always @(negedge clka) begin
    #1;
    if (rsta && rsp_valid && rsp_ready) begin
      rsp_n++;
      chk("rsp_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("rdata", rsp_rdata, exp_q.pop_front());
    end
  end

  task automatic issue(input logic we, input int a, input logic [WIDTH-1:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = ADDR'(a); cmd_wdata = d;
    #1;
    while (!cmd_ready && n < 3000) begin @(negedge clka); #1; n++; end
    chk("accept", cmd_ready, 1);
    if (we && n != 0) wr_stall++;
    if (cmd_ready) begin
      if (we) ref_mem[a] = d;
      else exp_q.push_back(ref_mem[a]);
    end
    @(negedge clka);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge clka);
    #2 chk("drain", exp_q.size(), 0);
  endtask

  task automatic after_release();
`ifdef RAM_CLEAR_EN
    int n = 0;
    while (busy && n < 3000) begin @(negedge clka); #1; n++; end
    chk("busy_len", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clka);
`else
    chk("busy_off", busy, 0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0; rsta = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    #5 rsta = 1'b0;
    #1 chk_zero("rst");
    @(negedge clka); @(negedge clka);
    rsta = 1'b1;
    #1;
`ifdef RAM_CLEAR_EN
    chk("busy_on", busy, 1);
    chk("rdy_clear", cmd_ready, 0);
`else
    chk("rdy_first", cmd_ready, 1);
`endif
    after_release();
    rsp_ready = 1'b1;
    issue(0, 1023, '0);
    issue(0, 500, '0);
    drain();
    // write/read latency
    issue(1, 100, 32'h12);
    issue(0, 100, '0);
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      #2 chk("lat", rsp_valid, k == RD_LAT + 2);
      if (k < RD_LAT + 2) @(negedge clka);
    end
    drain();
    // fill then stream back
    wr_stall = 0;
    for (int i = 0; i < DEPTH; i++) issue(1, i, WIDTH'(i));
    chk("wr_stall", wr_stall, 0);
    base = rsp_n;
    for (int i = 0; i < DEPTH; i++) issue(0, i, '0);
    drain();
    chk("rd_cnt", rsp_n - base, DEPTH);
    // read right after write to the same address
    issue(1, 300, 32'hDEAD_BEEF);
    issue(0, 300, '0);
    drain();
    // credit stall with consumer held off
    @(negedge clka);
    rsp_ready = 1'b0; acc = 0; base = rsp_n;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = acc < 4; cmd_we = 1'b0; cmd_addr = ADDR'(200 + acc);
      #1;
      if (cmd_valid && cmd_ready) begin exp_q.push_back(ref_mem[200 + acc]); acc++; end
      @(negedge clka);
    end
    chk("stall_acc", acc, 2);
    #1;
    chk("stall_rdy", cmd_ready, 0);
    chk("stall_vld", rsp_valid, 1);
    chk("stall_rsp", rsp_n - base, 0);
    @(negedge clka);
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      cmd_valid = 1'b1; cmd_addr = ADDR'(200 + acc);
      #1;
      if (cmd_ready) begin exp_q.push_back(ref_mem[200 + acc]); acc++; end
      @(negedge clka);
    end
    cmd_valid = 1'b0;
    chk("stall_all", acc, 4);
    drain();
    chk("stall_cnt", rsp_n - base, 4);
    // reset with two reads in flight
    @(negedge clka);
    rsp_ready = 1'b0;
    issue(0, 10, '0);
    issue(0, 11, '0);
    rsta = 1'b0;
    #1 chk_zero("rst_mid");
    exp_q.delete();
    @(negedge clka); @(negedge clka);
    rsta = 1'b1;
    #1;
    after_release();
    rsp_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clka); #2 if (rsp_valid) acc++; end
    chk("rst_stale", acc, 0);
    base = rsp_n;
    @(negedge clka);
    issue(0, 12, '0);
    drain();
    chk("post_rst", rsp_n - base, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
